axi4_slave_ctrl: RTL and testbench

AXI4 slave front-end that converts AXI4 INCR bursts into single-port word accesses on the on-chip memory's mem_en/mem_we/mem_addr/mem_wdata/mem_rdata interface.
- Sits directly upstream of the memory array.
- One transaction (write or read) in flight at a time.
- Fixed 4-byte beats; no byte strobes.

---
 rtl/axi4_slave_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_axi4_slave_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/axi4_slave_ctrl.sv
// axi4_slave_ctrl: AXI4 INCR-burst slave bridging to a single-port word memory; define AXI_OOR_WRAP_EN to wrap out-of-range addresses instead of erroring
module axi4_slave_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int MEM_DEPTH      = 1024,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [ADDR_WIDTH-1:0]     AWADDR,
  input  logic [7:0]                AWLEN,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [DATA_WIDTH-1:0]     WDATA,
  input  logic                      WLAST,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [ADDR_WIDTH-1:0]     ARADDR,
  input  logic [7:0]                ARLEN,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                RRESP,
  output logic                      RLAST,
  output logic                      RVALID,
  input  logic                      RREADY,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);
  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_ADDR, RD_WAIT, RD_DATA} state_t;
  state_t state_q, state_d, st;
  logic [MEM_ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [7:0] len_q, len_d, beat_q, beat_d, len;
  logic err_q, err_d, werr_q, werr_d, rd_first_q, rd_first_d, rlast_q, rlast_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] addr;
  logic aw_win, ar_win, aw_hs, ar_hs, range_err, last_beat, unused_addr;

  assign aw_win      = AWVALID && (!ARVALID || !rd_first_q);
  assign ar_win      = ARVALID && (!AWVALID || rd_first_q);
  assign addr        = aw_win ? AWADDR : ARADDR;
  assign len         = aw_win ? AWLEN : ARLEN;
  assign last_beat   = beat_q == len_q;
  assign unused_addr = ^addr;
`ifdef AXI_OOR_WRAP_EN
  assign range_err = 1'b0;
`else
  localparam logic [MEM_ADDR_WIDTH+8:0] LAST_WORD = (MEM_ADDR_WIDTH+9)'(MEM_DEPTH - 1);
  logic [MEM_ADDR_WIDTH+8:0] end_word;
  assign end_word  = {9'd0, addr[MEM_ADDR_WIDTH+1:2]} + {{(MEM_ADDR_WIDTH+1){1'b0}}, len};
  assign range_err = (|addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2]) || (end_word > LAST_WORD);
`endif

  assign mem_addr  = mem_en ? cur_q : '0;
  assign mem_wdata = mem_we ? WDATA : '0;
  assign BRESP     = bresp_q;
  assign RDATA     = rdata_q;
  assign RRESP     = rresp_q;
  assign RLAST     = rlast_q;

  // Next state, burst bookkeeping and handshake/strobe outputs; a held reset forces the idle view
  always_comb begin
    st         = ARESETn ? state_q : IDLE;
    state_d    = state_q;
    cur_d      = cur_q;
    len_d      = len_q;
    beat_d     = beat_q;
    err_d      = err_q;
    werr_d     = werr_q;
    rd_first_d = rd_first_q;
    bresp_d    = bresp_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    rlast_d    = rlast_q;
    AWREADY    = 1'b0;
    ARREADY    = 1'b0;
    WREADY     = 1'b0;
    BVALID     = 1'b0;
    RVALID     = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    aw_hs      = 1'b0;
    ar_hs      = 1'b0;
    case (st)
      IDLE: begin
        AWREADY = ARESETn && !ar_win;
        ARREADY = ARESETn && !aw_win;
        aw_hs   = AWVALID && AWREADY;
        ar_hs   = ARVALID && ARREADY;
        if (aw_hs || ar_hs) begin
          cur_d   = addr[MEM_ADDR_WIDTH+1:2];
          len_d   = len;
          beat_d  = '0;
          err_d   = range_err;
          werr_d  = 1'b0;
          state_d = aw_hs ? WR_DATA : RD_ADDR;
        end
      end
      WR_DATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          mem_en = !err_q;
          mem_we = !err_q;
          cur_d  = cur_q + MEM_ADDR_WIDTH'(1);
          beat_d = beat_q + 8'd1;
          werr_d = werr_q || (WLAST != last_beat);
          if (last_beat) begin
            state_d = WR_RESP;
            bresp_d = (err_q || werr_d) ? 2'b10 : 2'b00;
          end
        end
      end
      WR_RESP: begin
        BVALID = 1'b1;
        if (BREADY) begin
          state_d    = IDLE;
          rd_first_d = 1'b1;
        end
      end
      RD_ADDR: begin
        mem_en  = !err_q;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        rdata_d = err_q ? '0 : mem_rdata;
        rresp_d = err_q ? 2'b10 : 2'b00;
        rlast_d = last_beat;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        RVALID = 1'b1;
        if (RREADY) begin
          if (last_beat) begin
            state_d    = IDLE;
            rd_first_d = 1'b0;
          end else begin
            cur_d   = cur_q + MEM_ADDR_WIDTH'(1);
            beat_d  = beat_q + 8'd1;
            state_d = RD_ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
      werr_q     <= 1'b0;
      rd_first_q <= 1'b0;
      bresp_q    <= 2'b00;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
      rlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      werr_q     <= werr_d;
      rd_first_q <= rd_first_d;
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      rlast_q    <= rlast_d;
    end
  end
endmodule

// File: tb/tb_axi4_slave_ctrl.sv
// tb_axi4_slave_ctrl: randomized self-checking bench with a word-array reference model of the AXI4 slave bridge
module tb_axi4_slave_ctrl;
  localparam int MD = 1024;
  logic ACLK = 1'b0, ARESETn = 1'b0;
  logic [15:0] AWADDR = '0, ARADDR = '0;
  logic [7:0] AWLEN = '0, ARLEN = '0;
  logic AWVALID = 1'b0, AWREADY, WLAST = 1'b0, WVALID = 1'b0, WREADY, BVALID, BREADY = 1'b0;
  logic ARVALID = 1'b0, ARREADY, RLAST, RVALID, RREADY = 1'b0;
  logic [31:0] WDATA = '0, RDATA, mem_wdata, mem_rdata;
  logic [1:0] BRESP, RRESP;
  logic mem_en, mem_we;
  logic [9:0] mem_addr;
  logic [31:0] mem [MD];
  logic [31:0] ref_mem [MD];
  bit inited = 1'b0;
  bit rd_first = 1'b0;
  int strobes = 0;
  int n_chk = 0, n_pass = 0;

  always #5 ACLK = ~ACLK;

  axi4_slave_ctrl dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] seed_word(input int i);
    return (i * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic bit oor(input logic [15:0] a, input int len);
`ifdef AXI_OOR_WRAP_EN
    return 1'b0;
`else
    return (a[15:12] != 4'd0) || (int'(a[11:2]) + len > MD - 1);
`endif
  endfunction

  // Memory array the bridge drives: one-cycle read latency, strobe counter
  always @(posedge ACLK) begin
    if (!inited) begin
      for (int i = 0; i < MD; i++) mem[i] <= seed_word(i);
      inited <= 1'b1;
    end else if (mem_en) begin
      strobes <= strobes + 1;
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic arb(input bit exp_rd);
    AWADDR = '0; ARADDR = '0; AWLEN = '0; ARLEN = '0;
    AWVALID = 1'b1; ARVALID = 1'b1;
    @(negedge ACLK);
    check("arb_grant", {AWREADY, ARREADY}, exp_rd ? 2'b01 : 2'b10);
    AWVALID = 1'b0; ARVALID = 1'b0;
    @(posedge ACLK); #1;
  endtask

  task automatic wr(input logic [15:0] a, input int len, input logic [31:0] base, input bit rnd, input int bad);
    bit e;
    int s0, sw, b;
    logic [31:0] d;
    logic [1:0] er;
    e = oor(a, len); s0 = strobes; sw = int'(a[11:2]);
    er = (e || bad == 1 || (bad == 2 && len > 0)) ? 2'b10 : 2'b00;
    AWADDR = a; AWLEN = 8'(len); AWVALID = 1'b1;
    @(negedge ACLK);
    b = 0;
    while (!AWREADY && b < 20) begin @(negedge ACLK); b++; end
    if (!AWREADY) check("aw_timeout", 0, 1);
    @(posedge ACLK); #1 AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      d = rnd ? $urandom : base * (i + 1);
      WDATA = d; WVALID = 1'b1;
      WLAST = (i == len) ? (bad != 1) : (bad == 2 && i == 0);
      @(negedge ACLK);
      b = 0;
      while (!WREADY && b < 20) begin @(negedge ACLK); b++; end
      if (!WREADY) check("w_timeout", 0, 1);
      check("w_strobe", {mem_en, mem_we}, e ? 2'b00 : 2'b11);
      if (!e) begin
        check("w_addr", mem_addr, (sw + i) % MD);
        check("w_data", mem_wdata, d);
        ref_mem[(sw + i) % MD] = d;
      end
      @(posedge ACLK); #1 WVALID = 1'b0; WLAST = 1'b0;
      if (rnd && i < len && $urandom_range(0, 3) == 0) begin @(posedge ACLK); #1; end
    end
    @(negedge ACLK);
    check("b_next", BVALID, 1);
    b = 0;
    while (!BVALID && b < 20) begin @(negedge ACLK); b++; end
    repeat (rnd ? $urandom_range(0, 2) : 0) begin
      check("b_hold", {BVALID, BRESP}, {1'b1, er});
      @(negedge ACLK);
    end
    check("b_resp", BRESP, er);
    BREADY = 1'b1;
    @(posedge ACLK); #1 BREADY = 1'b0;
    check("w_strobes", strobes - s0, e ? 0 : len + 1);
    rd_first = 1'b1;
  endtask

  task automatic ar_send(input logic [15:0] a, input int len);
    int b;
    ARADDR = a; ARLEN = 8'(len); ARVALID = 1'b1;
    @(negedge ACLK);
    b = 0;
    while (!ARREADY && b < 20) begin @(negedge ACLK); b++; end
    if (!ARREADY) check("ar_timeout", 0, 1);
    @(posedge ACLK); #1 ARVALID = 1'b0;
  endtask

  task automatic r_beat(input logic [31:0] exp, input logic [1:0] resp, input bit lst, input int stall_n, input bit ack);
    int n;
    @(negedge ACLK);
    n = 0;
    while (!RVALID && n < 20) begin @(negedge ACLK); n++; end
    check("r_latency", n, 2);
    check("r_data", RDATA, exp);
    check("r_resp", RRESP, resp);
    check("r_last", RLAST, lst);
    repeat (stall_n) begin
      @(posedge ACLK); #1;
      @(negedge ACLK);
      check("r_hold", {RVALID, RLAST, RRESP, RDATA}, {1'b1, lst, resp, exp});
    end
    if (ack) begin
      RREADY = 1'b1;
      @(posedge ACLK); #1 RREADY = 1'b0;
    end
  endtask

  task automatic rd(input logic [15:0] a, input int len, input int stall_beat, input int stall_n);
    bit e;
    int s0, sw;
    e = oor(a, len); s0 = strobes; sw = int'(a[11:2]);
    ar_send(a, len);
    for (int i = 0; i <= len; i++)
      r_beat(e ? 32'd0 : ref_mem[(sw + i) % MD], e ? 2'b10 : 2'b00, i == len, i == stall_beat ? stall_n : 0, 1'b1);
    check("r_strobes", strobes - s0, e ? 0 : len + 1);
    rd_first = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0;
    logic [15:0] a;
    int len;
    for (int i = 0; i < MD; i++) ref_mem[i] = seed_word(i);
    AWVALID = 1'b1; ARVALID = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    check("rst_outputs", {AWREADY, ARREADY, BVALID, RVALID, mem_en, RLAST}, 6'b0);
    check("rst_rdata", RDATA, 0);
    @(posedge ACLK); #1 ARESETn = 1'b1; AWVALID = 1'b0; ARVALID = 1'b0;
    arb(1'b0);
    wr(16'h0010, 0, 32'hDEADBEEF, 1'b0, 0);
    arb(1'b1);
    wr(16'h0100, 3, 32'h11, 1'b0, 0);
    rd(16'h0100, 3, 1, 3);
    arb(1'b0);
    wr(16'h0FFC, 1, 32'hCAFE0001, 1'b0, 0);
    rd(16'h0FFC, 1, 0, 0);
    wr(16'h0200, 2, 32'h0A0A0A0A, 1'b0, 1);
    wr(16'h0210, 2, 32'h0B0B0B0B, 1'b0, 2);
    wr(16'h1000, 0, 32'h12345678, 1'b0, 0);
    rd(16'h8004, 0, 0, 1);
    rd(16'h0200, 2, 2, 1);
    ar_send(16'h0040, 3);
    r_beat(ref_mem[16], 2'b00, 1'b0, 0, 1'b1);
    r_beat(ref_mem[17], 2'b00, 1'b0, 0, 1'b0);
    s0 = strobes;
    @(posedge ACLK); #1 ARESETn = 1'b0;
    @(negedge ACLK);
    check("rst_mid_rvalid", {RVALID, mem_en}, 2'b00);
    @(posedge ACLK); #1 ARESETn = 1'b1;
    @(negedge ACLK);
    check("rst_mid_idle", {RVALID, AWREADY, ARREADY}, 3'b011);
    check("rst_mid_strobes", strobes - s0, 0);
    rd_first = 1'b0;
    @(posedge ACLK); #1;
    rd(16'h0000, 0, 0, 0);
    for (int k = 0; k < 40; k++) begin
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : {4'b0, 10'($urandom_range(0, MD - 1)), 2'($urandom)};
      len = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1)
        wr(a, len, 32'd0, 1'b1, ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0);
      else
        rd(a, len, $urandom_range(0, len), $urandom_range(0, 2));
      if (k % 8 == 0) arb(rd_first);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
